majority_checker: RTL and testbench

//  Self-checking response monitor for an N-input majority gate.

---
 rtl/maj_chk_pkg.sv | 22 ++
 rtl/maj_ref_model.sv | 19 +
 rtl/majority_checker.sv | 122 ++++++++++++
 tb/tb_majority_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/maj_chk_pkg.sv
// Shared state encoding and population-count helper for the majority checker.
package maj_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_N = 7;

  // Callers zero-extend narrower vectors to MAX_N bits.
  function automatic logic [2:0] popcount(input logic [MAX_N-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/maj_ref_model.sv
// Combinational reference: expected majority output for an N-bit input vector.
module maj_ref_model
  import maj_chk_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] in_vec,
  output logic         expected
);

  logic [MAX_N-1:0] v_ext;

  always_comb begin
    v_ext          = '0;
    v_ext[N-1:0]   = in_vec;
    expected       = (popcount(v_ext) > 3'(N / 2));
  end

endmodule

// File: rtl/majority_checker.sv
// Response monitor for an N-input majority gate: FSM, coverage, saturating error count.
// Optional first-mismatch capture enabled by defining MAJ_CHK_CAPTURE_EN.
module majority_checker
  import maj_chk_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [N-1:0]      in_vec,
  input  logic              dut_z,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N-1:0]   covered,
  output logic              cov_full,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [N-1:0]      first_err_vec
);

  localparam int unsigned COV_W = 2**N;

  state_e             state_q, state_d;
  logic [COV_W-1:0]   covered_q, covered_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [COV_W-1:0]   onehot, cov_next;
  logic               expected, mismatch, accept;
`ifdef MAJ_CHK_CAPTURE_EN
  logic               fe_valid_q, fe_valid_d;
  logic [N-1:0]       fe_vec_q, fe_vec_d;
`endif

  maj_ref_model #(.N(N)) u_ref (
    .in_vec   (in_vec),
    .expected (expected)
  );

  always_comb begin
    state_d   = state_q;
    covered_d = covered_q;
    err_cnt_d = err_cnt_q;
`ifdef MAJ_CHK_CAPTURE_EN
    fe_valid_d = fe_valid_q;
    fe_vec_d   = fe_vec_q;
`endif
    onehot         = '0;
    onehot[in_vec] = 1'b1;
    cov_next       = covered_q | onehot;
    // Case inequality so X/Z on the sample is reported as a mismatch.
    mismatch       = (dut_z !== expected);
    accept         = (state_q == S_RUN) && in_valid;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          covered_d = '0;
          err_cnt_d = '0;
`ifdef MAJ_CHK_CAPTURE_EN
          fe_valid_d = 1'b0;
          fe_vec_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (accept) begin
          covered_d = cov_next;
          if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
`ifdef MAJ_CHK_CAPTURE_EN
          if (mismatch && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_vec_d   = in_vec;
          end
`endif
        end
        if ((accept && (&cov_next)) || stop) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      covered_q <= '0;
      err_cnt_q <= '0;
`ifdef MAJ_CHK_CAPTURE_EN
      fe_valid_q <= 1'b0;
      fe_vec_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      covered_q <= covered_d;
      err_cnt_q <= err_cnt_d;
`ifdef MAJ_CHK_CAPTURE_EN
      fe_valid_q <= fe_valid_d;
      fe_vec_q   <= fe_vec_d;
`endif
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign covered  = covered_q;
  assign cov_full = &covered_q;
  assign err_cnt  = err_cnt_q;
  assign pass     = done && (err_cnt_q == '0) && cov_full;

`ifdef MAJ_CHK_CAPTURE_EN
  assign first_err_valid = fe_valid_q;
  assign first_err_vec   = fe_vec_q;
`else
  assign first_err_valid = 1'b0;
  assign first_err_vec   = '0;
`endif

endmodule

// File: tb/tb_majority_checker.sv
// Directed, table-driven bench for majority_checker (N=3) plus a narrow-counter instance.
module tb_majority_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, in_valid, dut_z;
  logic [2:0] in_vec;
  logic       busy, done, pass, cov_full, fe_valid;
  logic [7:0] covered, err_cnt;
  logic [2:0] fe_vec;

  logic       s2_start, s2_stop, s2_valid, s2_z;
  logic [2:0] s2_vec;
  logic       s2_busy, s2_done, s2_pass, s2_cov_full, s2_fe_valid;
  logic [7:0] s2_covered;
  logic [1:0] s2_err;
  logic [2:0] s2_fe_vec;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  majority_checker #(.N(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_vec(in_vec), .dut_z(dut_z), .busy(busy), .done(done), .pass(pass),
    .covered(covered), .cov_full(cov_full), .err_cnt(err_cnt),
    .first_err_valid(fe_valid), .first_err_vec(fe_vec)
  );

  majority_checker #(.N(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .stop(s2_stop), .in_valid(s2_valid),
    .in_vec(s2_vec), .dut_z(s2_z), .busy(s2_busy), .done(s2_done), .pass(s2_pass),
    .covered(s2_covered), .cov_full(s2_cov_full), .err_cnt(s2_err),
    .first_err_valid(s2_fe_valid), .first_err_vec(s2_fe_vec)
  );

  typedef struct {
    logic       st, sp, v;
    logic [2:0] vec;
    logic       z;
    logic       e_busy, e_done, e_pass;
    logic [7:0] e_cov, e_err;
  } vec_t;

  vec_t tbl[$];

  // Majority of 3 by hand: patterns 011,101,110,111 -> 1.
  logic [7:0] maj_tab = 8'b1110_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, sp, v, input logic [2:0] vec, input logic z,
                     input logic eb, ed, ep, input logic [7:0] ec, ee);
    vec_t r;
    r.st = st; r.sp = sp; r.v = v; r.vec = vec; r.z = z;
    r.e_busy = eb; r.e_done = ed; r.e_pass = ep; r.e_cov = ec; r.e_err = ee;
    tbl.push_back(r);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] cov;
    logic [7:0] err;
    logic       z;

    rst = 1'b1; start = 0; stop = 0; in_valid = 0; in_vec = '0; dut_z = 0;
    s2_start = 0; s2_stop = 0; s2_valid = 0; s2_vec = '0; s2_z = 0;
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_cov", covered, 0); chk("rst_err", err_cnt, 0); chk("rst_fe", fe_valid, 0);
    rst = 1'b0;
    step();

    // T4: IDLE samples and stop are dropped; start+valid drops the sample; RUN with valid=0 ignored
    add(0,0,1,3'd7,0, 0,0,0, 8'h00, 8'h00);
    add(0,1,1,3'd2,1, 0,0,0, 8'h00, 8'h00);
    add(1,0,1,3'd5,0, 1,0,0, 8'h00, 8'h00);
    add(0,0,0,3'd5,0, 1,0,0, 8'h00, 8'h00);
    // T1: full correct sweep
    cov = 8'h00;
    for (int k = 0; k < 8; k++) begin
      cov[k] = 1'b1;
      add(0,0,1,3'(k),maj_tab[k], k<7, k==7, k==7, cov, 8'h00);
    end
    // T2: sweep with z forced 0 on 011 and 110
    add(1,0,0,3'd0,0, 1,0,0, 8'h00, 8'h00);
    cov = 8'h00; err = 8'h00;
    for (int k = 0; k < 8; k++) begin
      z = (k == 3 || k == 6) ? 1'b0 : maj_tab[k];
      if (k == 3 || k == 6) err++;
      cov[k] = 1'b1;
      add(0,0,1,3'(k),z, k<7, k==7, 0, cov, err);
    end
    // Samples in DONE are dropped
    add(0,0,1,3'd1,1, 0,1,0, 8'hFF, 8'h02);

    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; in_valid = tbl[i].v;
      in_vec = tbl[i].vec; dut_z = tbl[i].z;
      step();
      chk($sformatf("r%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("r%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("r%0d_pass", i), pass, tbl[i].e_pass);
      chk($sformatf("r%0d_cov", i), covered, tbl[i].e_cov);
      chk($sformatf("r%0d_err", i), err_cnt, tbl[i].e_err);
    end
`ifdef MAJ_CHK_CAPTURE_EN
    chk("t2_fe_valid", fe_valid, 1); chk("t2_fe_vec", fe_vec, 3'b011);
`else
    chk("t2_fe_valid", fe_valid, 0); chk("t2_fe_vec", fe_vec, 0);
`endif
    chk("t2_cov_full", cov_full, 1);

    // T3: restart from DONE, 5 samples with stop on the last; start mid-run ignored
    start = 1; stop = 0; in_valid = 0; step();
    chk("t3_busy", busy, 1); chk("t3_err_clr", err_cnt, 0); chk("t3_fe_clr", fe_valid, 0);
    start = 0;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); stop = (k == 4); in_valid = 1; in_vec = 3'(k); dut_z = maj_tab[k];
      step();
    end
    start = 0; stop = 0; in_valid = 0;
    chk("t3_done", done, 1); chk("t3_cov", covered, 8'h1F);
    chk("t3_cov_full", cov_full, 0); chk("t3_pass", pass, 0); chk("t3_err", err_cnt, 0);

    // T5: async reset mid-run, off-edge
    start = 1; step(); start = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_vec = 3'(k); dut_z = ~maj_tab[k]; step();
    end
    in_valid = 0;
    chk("t5_pre_cov", covered, 8'h0F); chk("t5_pre_err", err_cnt, 4);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_cov", covered, 0);
    chk("t5_err", err_cnt, 0); chk("t5_fe", fe_valid, 0); chk("t5_fe_vec", fe_vec, 0);
    #3 rst = 1'b0;
    step();
    chk("t5_idle", busy, 0);

    // T6: 2-bit counter saturates, cleared on restart from DONE
    s2_start = 1; step(); s2_start = 0;
    for (int k = 0; k < 5; k++) begin
      s2_valid = 1; s2_vec = 3'd0; s2_z = 1; step();
      chk($sformatf("t6_err%0d", k), s2_err, (k < 3) ? k + 1 : 3);
    end
    s2_valid = 0; s2_stop = 1; step(); s2_stop = 0;
    chk("t6_done", s2_done, 1);
    s2_start = 1; step(); s2_start = 0;
    chk("t6_restart_err", s2_err, 0); chk("t6_restart_busy", s2_busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
